// File: rtl/lcd_bus_decoder.sv
// lcd_bus_decoder: decodes an 8080 panel bus into commands, window registers and RAMWR pixel writes.
// Define LCD_BUS_SYNC_EN to put a 2-flop synchronizer ahead of the sample register for a bus not driven from clk.
module lcd_bus_decoder (
   input  logic        clk,
   input  logic        rstn,
   input  logic        lcd_cs,
   input  logic        lcd_rs,
   input  logic        lcd_wr,
   input  logic        lcd_rd,
   input  logic [15:0] lcd_data,
   output logic        cmd_valid,
   output logic [7:0]  cmd_code,
   output logic        pix_valid,
   output logic [15:0] pix_x,
   output logic [15:0] pix_y,
   output logic [15:0] pix_data,
   output logic        frame_done,
   output logic [15:0] win_sc,
   output logic [15:0] win_ec,
   output logic [15:0] win_sp,
   output logic [15:0] win_ep,
   output logic        win_err
);
   typedef enum logic [2:0] {IDLE, CASET, PASET, RAMWR, IGNORE} state_t;
   localparam logic [18:0] BUS_IDLE = {3'b111, 16'h0000};
   localparam logic [15:0] DEF_EC = 16'h00EF;
   localparam logic [15:0] DEF_EP = 16'h013F;
   state_t state, state_n;
   logic [18:0] bus;
   logic s_cs, s_rs, s_wr, s_wr_q, s_cs_q;
   logic [15:0] s_data, px, py, p_start, p_end, new_sc, new_ec, new_sp, new_ep;
   logic [23:0] par;
   logic [1:0] cnt;
   logic [7:0] code;
   logic stb, cmd_stb, dat_stb, par_stb, par_last, pix_stb, cs_rise, last_x, last_y, unused_rd;
   assign unused_rd = lcd_rd;
`ifdef LCD_BUS_SYNC_EN
   // data rides through the same stages as wr so it stays aligned with the strobe
   logic [18:0] sync1, sync2;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         sync1 <= BUS_IDLE;
         sync2 <= BUS_IDLE;
      end else begin
         sync1 <= {lcd_cs, lcd_rs, lcd_wr, lcd_data};
         sync2 <= sync1;
      end
   assign bus = sync2;
`else
   assign bus = {lcd_cs, lcd_rs, lcd_wr, lcd_data};
`endif
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         {s_cs, s_rs, s_wr, s_data} <= BUS_IDLE;
         s_wr_q <= 1'b1;
         s_cs_q <= 1'b1;
      end else begin
         {s_cs, s_rs, s_wr, s_data} <= bus;
         s_wr_q <= s_wr;
         s_cs_q <= s_cs;
      end
   assign code     = s_data[7:0];
   assign stb      = ~s_cs & s_wr & ~s_wr_q;
   assign cmd_stb  = stb & ~s_rs;
   assign dat_stb  = stb & s_rs;
   assign cs_rise  = s_cs & ~s_cs_q;
   assign par_stb  = dat_stb & (state == CASET || state == PASET);
   assign par_last = par_stb & (cnt == 2'd3);
   assign pix_stb  = dat_stb & (state == RAMWR) & ~win_err;
   // par holds the three earlier parameters; the 4th arrives on the bus
   assign p_start  = par[23:8];
   assign p_end    = {par[7:0], code};
   assign new_sc   = state == CASET ? p_start : win_sc;
   assign new_ec   = state == CASET ? p_end : win_ec;
   assign new_sp   = state == PASET ? p_start : win_sp;
   assign new_ep   = state == PASET ? p_end : win_ep;
   assign last_x   = px == win_ec;
   assign last_y   = py == win_ep;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (cmd_stb)
         state_n = code == 8'h2A ? CASET :
                   code == 8'h2B ? PASET :
                   code == 8'h2C ? RAMWR :
                   code == 8'h01 ? IDLE : IGNORE;
      else if (par_last)
         state_n = IDLE;
   end
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         cmd_valid  <= 1'b0;
         pix_valid  <= 1'b0;
         frame_done <= 1'b0;
         cmd_code   <= '0;
         pix_x      <= '0;
         pix_y      <= '0;
         pix_data   <= '0;
         cnt        <= '0;
         par        <= '0;
         px         <= '0;
         py         <= '0;
         win_sc     <= '0;
         win_ec     <= DEF_EC;
         win_sp     <= '0;
         win_ep     <= DEF_EP;
         win_err    <= 1'b0;
      end else begin
         cmd_valid  <= cmd_stb;
         pix_valid  <= pix_stb;
         frame_done <= pix_stb & last_x & last_y;
         if (cmd_stb) cmd_code <= code;
         if (cmd_stb || cs_rise) cnt <= '0;
         else if (par_stb) cnt <= cnt + 2'd1;
         if (par_stb) par <= {par[15:0], code};
         if (cmd_stb && code == 8'h01) begin
            win_sc  <= '0;
            win_ec  <= DEF_EC;
            win_sp  <= '0;
            win_ep  <= DEF_EP;
            win_err <= 1'b0;
         end else if (par_last) begin
            win_sc  <= new_sc;
            win_ec  <= new_ec;
            win_sp  <= new_sp;
            win_ep  <= new_ep;
            win_err <= (new_sc > new_ec) || (new_sp > new_ep);
         end
         if (cmd_stb && code == 8'h2C) begin
            px <= win_sc;
            py <= win_sp;
         end else if (pix_stb) begin
            pix_x    <= px;
            pix_y    <= py;
            pix_data <= s_data;
            px       <= last_x ? win_sc : px + 16'd1;
            py       <= last_x ? (last_y ? win_sp : py + 16'd1) : py;
         end
      end
endmodule

// File: tb/tb_lcd_bus_decoder.sv
// tb_lcd_bus_decoder: randomized and directed bus traffic checked against a window/raster reference model.
module tb_lcd_bus_decoder;
   logic clk = 0, rstn = 0, lcd_cs = 1, lcd_rs = 1, lcd_wr = 1, lcd_rd = 1;
   logic [15:0] lcd_data = 0;
   logic cmd_valid, pix_valid, frame_done, win_err;
   logic [7:0] cmd_code;
   logic [15:0] pix_x, pix_y, pix_data, win_sc, win_ec, win_sp, win_ep;
`ifdef LCD_BUS_SYNC_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 2;
`endif
   lcd_bus_decoder dut (
      .clk(clk), .rstn(rstn), .lcd_cs(lcd_cs), .lcd_rs(lcd_rs), .lcd_wr(lcd_wr), .lcd_rd(lcd_rd),
      .lcd_data(lcd_data), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .frame_done(frame_done),
      .win_sc(win_sc), .win_ec(win_ec), .win_sp(win_sp), .win_ep(win_ep), .win_err(win_err));
   always #5 clk = ~clk;
   int total = 0, bad = 0;
   logic [48:0] pix_q[$], exp_q[$];
   logic [7:0] cmd_q[$], exp_cmd[$];
   // reference model: mode 0 idle, 1 caset, 2 paset, 3 ramwr, 4 ignore
   logic [15:0] m_sc, m_ec, m_sp, m_ep;
   logic [7:0] m_par[4];
   bit m_err;
   int m_mode, m_cnt;
   longint m_idx;
   always @(negedge clk) begin
      if (pix_valid) pix_q.push_back({frame_done, pix_x, pix_y, pix_data});
      else if (frame_done) pix_q.push_back({1'b1, 48'h0});
      if (cmd_valid) cmd_q.push_back(cmd_code);
   end
   task automatic model_init();
      m_sc = 0; m_ec = 16'h00EF; m_sp = 0; m_ep = 16'h013F;
      m_err = 0; m_mode = 0; m_cnt = 0; m_idx = 0;
   endtask
   task automatic model_cmd(input logic [7:0] c);
      exp_cmd.push_back(c);
      m_cnt = 0;
      m_mode = c == 8'h2A ? 1 : c == 8'h2B ? 2 : c == 8'h2C ? 3 : c == 8'h01 ? 0 : 4;
      if (c == 8'h01) begin
         m_sc = 0; m_ec = 16'h00EF; m_sp = 0; m_ep = 16'h013F; m_err = 0;
      end
      if (c == 8'h2C) m_idx = 0;
   endtask
   task automatic model_data(input logic [15:0] d);
      longint w, h, x, y;
      if (m_mode == 1 || m_mode == 2) begin
         m_par[m_cnt] = d[7:0];
         m_cnt++;
         if (m_cnt == 4) begin
            if (m_mode == 1) begin
               m_sc = {m_par[0], m_par[1]}; m_ec = {m_par[2], m_par[3]};
            end else begin
               m_sp = {m_par[0], m_par[1]}; m_ep = {m_par[2], m_par[3]};
            end
            m_err = (m_sc > m_ec) || (m_sp > m_ep);
            m_mode = 0; m_cnt = 0;
         end
      end else if (m_mode == 3 && !m_err) begin
         w = longint'(m_ec) - longint'(m_sc) + 1;
         h = longint'(m_ep) - longint'(m_sp) + 1;
         x = longint'(m_sc) + m_idx % w;
         y = longint'(m_sp) + m_idx / w;
         exp_q.push_back({m_idx == w * h - 1, 16'(x), 16'(y), d});
         m_idx = (m_idx + 1) % (w * h);
      end
   endtask
   task automatic bus_wr(input logic rs, input logic [15:0] d);
      @(posedge clk); #1 lcd_cs = 0; lcd_rs = rs; lcd_data = d; lcd_wr = 0;
      @(posedge clk); @(posedge clk); #1 lcd_wr = 1;
      repeat (2) @(posedge clk);
   endtask
   task automatic send_cmd(input logic [7:0] c);
      bus_wr(1'b0, {8'($urandom), c});
      model_cmd(c);
   endtask
   task automatic send_data(input logic [15:0] d);
      bus_wr(1'b1, d);
      model_data(d);
   endtask
   task automatic send_win(input logic [7:0] c, input logic [15:0] s, input logic [15:0] e);
      send_cmd(c);
      send_data({8'($urandom), s[15:8]});
      send_data({8'($urandom), s[7:0]});
      send_data({8'($urandom), e[15:8]});
      send_data({8'($urandom), e[7:0]});
   endtask
   task automatic drain();
      repeat (LAT + 4) @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      repeat (3) @(posedge clk);
      #1 total++;
      if ({cmd_valid, pix_valid, frame_done, win_err} !== 4'b0) begin
         bad++; $display("FAIL reset_flags got=%b want=0000", {cmd_valid, pix_valid, frame_done, win_err});
      end
      total++;
      if ({cmd_code, pix_x, pix_y, pix_data} !== 56'h0) begin
         bad++; $display("FAIL reset_data got=%h want=0", {cmd_code, pix_x, pix_y, pix_data});
      end
      total++;
      if ({win_sc, win_ec, win_sp, win_ep} !== {16'h0, 16'h00EF, 16'h0, 16'h013F}) begin
         bad++; $display("FAIL reset_window got=%h %h %h %h want=0 ef 0 13f", win_sc, win_ec, win_sp, win_ep);
      end
      rstn = 1;
      model_init();
      drain();
      total++;
      if (cmd_q.size() + pix_q.size() != 0) begin
         bad++; $display("FAIL reset_release_pulses got=%0d want=0", cmd_q.size() + pix_q.size());
      end
   endtask
   task automatic test_window();
      send_win(8'h2A, 16'h0010, 16'h0013);
      send_win(8'h2B, 16'h0005, 16'h0006);
      drain();
      total++;
      if ({win_sc, win_ec, win_sp, win_ep, win_err} !== {16'h10, 16'h13, 16'h5, 16'h6, 1'b0}) begin
         bad++; $display("FAIL window_load got=%h %h %h %h err=%b want=10 13 5 6 err=0", win_sc, win_ec, win_sp, win_ep, win_err);
      end
      total++;
      if (cmd_q.size() != 2 || cmd_q[0] !== 8'h2A || cmd_q[1] !== 8'h2B) begin
         bad++; $display("FAIL window_cmds got n=%0d want 2A,2B", cmd_q.size());
      end
      total++;
      if (pix_q.size() != 0) begin
         bad++; $display("FAIL window_no_pix got=%0d want=0", pix_q.size());
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_frame();
      send_cmd(8'h2C);
      for (int i = 0; i < 8; i++) send_data(16'hA000 + 16'(i));
      send_data(16'hBEEF);
      drain();
      total++;
      if (pix_q.size() != exp_q.size()) begin
         bad++; $display("FAIL frame_count got=%0d want=%0d", pix_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
         total++;
         if (pix_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL frame_pix[%0d] got=%h want=%h", i, pix_q[i], exp_q[i]);
         end
      end
      total++;
      if (pix_q[7] !== {1'b1, 16'd19, 16'd6, 16'hA007}) begin
         bad++; $display("FAIL frame_last got=%h want=%h", pix_q[7], {1'b1, 16'd19, 16'd6, 16'hA007});
      end
      total++;
      if (pix_q[8] !== {1'b0, 16'd16, 16'd5, 16'hBEEF}) begin
         bad++; $display("FAIL frame_wrap got=%h want=%h", pix_q[8], {1'b0, 16'd16, 16'd5, 16'hBEEF});
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_err();
      send_win(8'h2A, 16'h0020, 16'h0010);
      drain();
      total++;
      if (win_err !== 1'b1 || m_err !== 1'b1) begin
         bad++; $display("FAIL err_set got=%b want=1", win_err);
      end
      send_cmd(8'h2C);
      for (int i = 0; i < 3; i++) send_data(16'(i + 1));
      drain();
      total++;
      if (pix_q.size() != 0) begin
         bad++; $display("FAIL err_discard got=%0d want=0", pix_q.size());
      end
      send_win(8'h2A, 16'h0010, 16'h0013);
      drain();
      total++;
      if (win_err !== 1'b0) begin
         bad++; $display("FAIL err_clear got=%b want=0", win_err);
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_abort();
      send_cmd(8'h2A);
      send_data(16'h0000);
      send_data(16'h0030);
      send_cmd(8'h2C);
      send_data(16'h1234);
      drain();
      total++;
      if ({win_sc, win_ec, win_sp, win_ep} !== {16'h10, 16'h13, 16'h5, 16'h6}) begin
         bad++; $display("FAIL abort_window got=%h %h %h %h want=10 13 5 6", win_sc, win_ec, win_sp, win_ep);
      end
      total++;
      if (cmd_code !== 8'h2C || cmd_q.size() != 2 || cmd_q[1] !== 8'h2C) begin
         bad++; $display("FAIL abort_cmd got=%h want=2c", cmd_code);
      end
      total++;
      if (pix_q.size() != 1 || pix_q[0] !== {1'b0, 16'h10, 16'h5, 16'h1234}) begin
         bad++; $display("FAIL abort_pointer got=%h want=%h", pix_q[0], {1'b0, 16'h10, 16'h5, 16'h1234});
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_cs_abort();
      send_cmd(8'h2A);
      send_data(16'h0000);
      send_data(16'h0050);
      @(posedge clk); #1 lcd_cs = 1;
      repeat (3) @(posedge clk);
      #1 lcd_cs = 0;
      m_cnt = 0;
      send_data(16'h0000);
      send_data(16'h0030);
      send_data(16'h0000);
      send_data(16'h0040);
      drain();
      total++;
      if ({win_sc, win_ec, win_err} !== {16'h30, 16'h40, 1'b0} || {m_sc, m_ec} !== {16'h30, 16'h40}) begin
         bad++; $display("FAIL cs_abort got=%h %h err=%b want=30 40 err=0", win_sc, win_ec, win_err);
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_latency();
      send_cmd(8'h2C);
      @(posedge clk); #1 lcd_cs = 0; lcd_rs = 1; lcd_data = 16'h4321; lcd_wr = 0;
      @(posedge clk); @(posedge clk); #1 lcd_wr = 1;
      model_data(16'h4321);
      for (int k = 1; k <= LAT + 1; k++) begin
         @(posedge clk); #1 total++;
         if (pix_valid !== (k == LAT)) begin
            bad++; $display("FAIL latency edge%0d got=%b want=%b", k, pix_valid, k == LAT);
         end
      end
      drain();
      total++;
      if (pix_q.size() != 1 || pix_q[0] !== exp_q[0]) begin
         bad++; $display("FAIL latency_pix got=%h want=%h", pix_q[0], exp_q[0]);
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_random();
      logic [7:0] others[6] = '{8'h00, 8'h11, 8'h29, 8'h36, 8'h3A, 8'hFF};
      int w, h, n;
      logic [15:0] sc, sp;
      for (int it = 0; it < 8; it++) begin
         w = $urandom_range(1, 4); h = $urandom_range(1, 3);
         sc = 16'($urandom_range(0, 400)); sp = 16'($urandom_range(0, 400));
         if ($urandom_range(0, 3) == 0) begin
            send_win(8'h2A, sc + 16'(w), sc);
            send_win(8'h2B, sp, sp + 16'(h - 1));
         end else if ($urandom_range(0, 1) == 0) begin
            send_win(8'h2A, sc, sc + 16'(w - 1));
            send_win(8'h2B, sp, sp + 16'(h - 1));
         end else begin
            send_win(8'h2B, sp, sp + 16'(h - 1));
            send_win(8'h2A, sc, sc + 16'(w - 1));
         end
         if ($urandom_range(0, 2) == 0) begin
            send_cmd(others[$urandom_range(0, 5)]);
            send_data(16'($urandom));
         end
         send_cmd(8'h2C);
         n = $urandom_range(0, 2 * w * h + 1);
         for (int i = 0; i < n; i++) send_data(16'($urandom));
         if ($urandom_range(0, 4) == 0) send_data(16'($urandom));
      end
      drain();
      total++;
      if (pix_q.size() != exp_q.size()) begin
         bad++; $display("FAIL rand_pix_count got=%0d want=%0d", pix_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < pix_q.size(); i++) begin
         total++;
         if (pix_q[i] !== exp_q[i]) begin
            bad++; $display("FAIL rand_pix[%0d] got=%h want=%h", i, pix_q[i], exp_q[i]);
         end
      end
      total++;
      if (cmd_q.size() != exp_cmd.size()) begin
         bad++; $display("FAIL rand_cmd_count got=%0d want=%0d", cmd_q.size(), exp_cmd.size());
      end
      for (int i = 0; i < exp_cmd.size() && i < cmd_q.size(); i++) begin
         total++;
         if (cmd_q[i] !== exp_cmd[i]) begin
            bad++; $display("FAIL rand_cmd[%0d] got=%h want=%h", i, cmd_q[i], exp_cmd[i]);
         end
      end
      total++;
      if ({win_sc, win_ec, win_sp, win_ep, win_err} !== {m_sc, m_ec, m_sp, m_ep, m_err}) begin
         bad++; $display("FAIL rand_window got=%h %h %h %h %b want=%h %h %h %h %b",
                         win_sc, win_ec, win_sp, win_ep, win_err, m_sc, m_ec, m_sp, m_ep, m_err);
      end
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
   endtask
   task automatic test_reset_mid();
      send_win(8'h2A, 16'h0010, 16'h0013);
      send_cmd(8'h2C);
      send_data(16'h0101);
      send_data(16'h0202);
      drain();
      cmd_q.delete(); exp_cmd.delete(); pix_q.delete(); exp_q.delete();
      @(posedge clk); #1 lcd_cs = 0; lcd_rs = 1; lcd_data = 16'h0303; lcd_wr = 0;
      @(posedge clk); @(posedge clk); #1 lcd_wr = 1;
      @(posedge clk); #1 rstn = 0;
      #1 total++;
      if ({cmd_valid, pix_valid, frame_done, win_err, cmd_code, pix_x, pix_y, pix_data} !== 60'h0) begin
         bad++; $display("FAIL midreset_outputs got=%h want=0",
                         {cmd_valid, pix_valid, frame_done, win_err, cmd_code, pix_x, pix_y, pix_data});
      end
      total++;
      if ({win_sc, win_ec, win_sp, win_ep} !== {16'h0, 16'h00EF, 16'h0, 16'h013F}) begin
         bad++; $display("FAIL midreset_window got=%h %h %h %h want=0 ef 0 13f", win_sc, win_ec, win_sp, win_ep);
      end
      repeat (2) @(posedge clk);
      #1 rstn = 1;
      model_init();
      send_data(16'h0404);
      drain();
      total++;
      if (pix_q.size() != 0 || exp_q.size() != 0) begin
         bad++; $display("FAIL midreset_no_pix got=%0d want=0", pix_q.size());
      end
   endtask
   initial begin
      model_init();
      test_reset();
      test_window();
      test_frame();
      test_err();
      test_abort();
      test_cs_abort();
      test_latency();
      test_random();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
